// File: rtl/clk_div_pkg.sv
// clk_div_n shared types and helpers.
// Optional feature macro: CLK_DIV_DUTY_PROG_EN.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int MIN_DIV = 2;

  function automatic int unsigned half_of(
    input int unsigned n
  );
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_if.sv
// clk_div_n control/status bundle.
// Optional feature macro: CLK_DIV_DUTY_PROG_EN (adds duty_hi).
interface clk_div_if #(
  parameter int DIV_W = 8
);

  logic             en;
  logic             load;
  logic [DIV_W-1:0] div_ratio;
`ifdef CLK_DIV_DUTY_PROG_EN
  logic [DIV_W-1:0] duty_hi;
`endif
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic             ratio_err;

  modport master (
`ifdef CLK_DIV_DUTY_PROG_EN
    output duty_hi,
`endif
    output en,
    output load,
    output div_ratio,
    input  clk_out,
    input  tick,
    input  busy,
    input  ratio_err
  );

  modport slave (
`ifdef CLK_DIV_DUTY_PROG_EN
    input  duty_hi,
`endif
    input  en,
    input  load,
    input  div_ratio,
    output clk_out,
    output tick,
    output busy,
    output ratio_err
  );

endinterface

// File: rtl/clk_div_ratio_reg.sv
// Pending/active ratio registers with clamping and sticky error.
// Optional feature macro: CLK_DIV_DUTY_PROG_EN.
module clk_div_ratio_reg
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div_ratio,
`ifdef CLK_DIV_DUTY_PROG_EN
  input  logic [DIV_W-1:0] i_duty_hi,
`endif
  input  logic             i_adopt,
  output logic [DIV_W-1:0] o_n,
  output logic [DIV_W-1:0] o_n_nxt,
  output logic [DIV_W-1:0] o_h_nxt,
  output logic             o_ratio_err
);

  localparam logic [DIV_W-1:0] DEF_N =
    DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DEF_H =
    DIV_W'(half_of(32'(DEFAULT_DIV)));
  localparam logic [DIV_W-1:0] MIN_N =
    DIV_W'(MIN_DIV);

  logic [DIV_W-1:0] r_act_n;
  logic [DIV_W-1:0] r_act_h;
  logic [DIV_W-1:0] r_pend_n;
  logic [DIV_W-1:0] r_pend_h;
  logic             r_pend_v;
  logic             r_err;

  logic             w_ld_low;
  logic [DIV_W-1:0] w_ld_n;
  logic [DIV_W-1:0] w_ld_h;
  logic             w_ld_bad;
  logic             w_take;

  assign w_ld_low = i_div_ratio < MIN_N;
  assign w_ld_n   = w_ld_low ? MIN_N : i_div_ratio;

`ifdef CLK_DIV_DUTY_PROG_EN
  logic w_h_lo;
  logic w_h_hi;

  // high time must leave at least one low cycle
  assign w_h_lo   = i_duty_hi == '0;
  assign w_h_hi   = i_duty_hi >= w_ld_n;
  assign w_ld_h   = w_h_lo ? DIV_W'(1) :
                    w_h_hi ? w_ld_n - DIV_W'(1) :
                    i_duty_hi;
  assign w_ld_bad = w_ld_low | w_h_lo | w_h_hi;
`else
  assign w_ld_h   = DIV_W'(half_of(32'(w_ld_n)));
  assign w_ld_bad = w_ld_low;
`endif

  assign w_take  = i_adopt & r_pend_v;
  assign o_n     = r_act_n;
  assign o_n_nxt = w_take ? r_pend_n : r_act_n;
  assign o_h_nxt = w_take ? r_pend_h : r_act_h;
  assign o_ratio_err = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_n  <= DEF_N;
      r_act_h  <= DEF_H;
      r_pend_n <= DEF_N;
      r_pend_h <= DEF_H;
      r_pend_v <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_act_n <= o_n_nxt;
      r_act_h <= o_h_nxt;
      if (i_load) begin
        r_pend_n <= w_ld_n;
        r_pend_h <= w_ld_h;
        r_pend_v <= 1'b1;
      end else if (w_take) begin
        r_pend_v <= 1'b0;
      end
      if (i_load && w_ld_bad) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable glitch-free integer clock divider.
// Optional feature macro: CLK_DIV_DUTY_PROG_EN.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input logic      clk,
  input logic      rst,
  clk_div_if.slave bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             r_p;
  logic             r_n;
  logic             w_p_nxt;

  logic [DIV_W-1:0] w_n;
  logic [DIV_W-1:0] w_n_nxt;
  logic [DIV_W-1:0] w_h_nxt;
  logic [DIV_W-1:0] w_last;
  logic             w_wrap;
  logic             w_busy;
  logic             w_adopt;

  clk_div_ratio_reg #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_ratio (
    .clk         (clk),
    .rst         (rst),
    .i_load      (bus.load),
    .i_div_ratio (bus.div_ratio),
`ifdef CLK_DIV_DUTY_PROG_EN
    .i_duty_hi   (bus.duty_hi),
`endif
    .i_adopt     (w_adopt),
    .o_n         (w_n),
    .o_n_nxt     (w_n_nxt),
    .o_h_nxt     (w_h_nxt),
    .o_ratio_err (bus.ratio_err)
  );

  assign w_last  = w_n - DIV_W'(1);
  assign w_busy  = r_state != IDLE;
  assign w_wrap  = w_busy && (r_cnt == w_last);
  assign w_adopt = (r_state == IDLE) | w_wrap;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.en) w_state_nxt = RUN;
      end
      RUN: begin
        if (!bus.en)
          w_state_nxt = w_wrap ? IDLE : STOPPING;
      end
      STOPPING: begin
        if (bus.en)      w_state_nxt = RUN;
        else if (w_wrap) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_cnt_nxt = '0;
    if (w_busy && !w_wrap && w_state_nxt != IDLE)
      w_cnt_nxt = r_cnt + DIV_W'(1);

    // phase for the period being entered uses the adopted H
    w_p_nxt = (w_state_nxt != IDLE) &&
              (w_cnt_nxt < w_h_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_p     <= w_p_nxt;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) r_n <= 1'b0;
    else     r_n <= r_p;
  end

`ifdef CLK_DIV_DUTY_PROG_EN
  assign bus.clk_out = r_p;
`else
  // odd ratios delay the rise by half a cycle
  assign bus.clk_out = r_p & (r_n | ~w_n[0]);
`endif

  assign bus.tick = w_busy && (r_cnt == '0);
  assign bus.busy = w_busy;

endmodule
